// File: rtl/exc_sequencer.sv
// -----------------------------------------------------------------------------
// exc_sequencer
//
// Purpose:
//   Sequences exceptions, interrupts and ERET between the MEM stage of a
//   5-stage pipeline and the CP0 register block. One event is accepted per
//   window. The sequencer then flushes the pipe, waits for data-memory traffic
//   to drain, issues a single-cycle commit to CP0 and finally redirects fetch
//   to the handler entry (exception/interrupt) or to EPC (ERET).
//
//   State walk: IDLE -> DRAIN -> COMMIT -> REDIRECT -> IDLE, one registered
//   state per step. All outputs are registered.
//
// Parameters:
//   HANDLER_ADDR   handler entry for exceptions and interrupts (BEV=1)
//   CNT_WIDTH      width of exc_count
//
// Optional feature (macro EXC_CNT_EN):
//   defined   : exc_count counts COMMITs of kind exception or interrupt,
//               wrapping at 2^CNT_WIDTH, cleared by rst.
//   undefined : exc_count is tied to zero, no counter flops.
//
// Ports:
//   clk            in   clock, all state on posedge
//   rst            in   synchronous active-high reset
//   mem_valid      in   MEM stage holds a valid instruction
//   mem_exc_vec    in   {PC_AdEL,RI,Ov,Sys,Bp,AdEL,AdES}
//   mem_pc         in   PC of the MEM-stage instruction
//   mem_bd         in   MEM-stage instruction is in a delay slot
//   mem_badvaddr   in   faulting address
//   mem_eret       in   MEM-stage instruction is ERET
//   int_pending    in   CP0 has an enabled, unmasked interrupt pending
//   mem_busy       in   data-memory transaction outstanding
//   epc_value      in   current CP0 EPC (sampled in COMMIT for ERET)
//   redirect_ready in   fetch accepts the redirect
//   flush          out  kill IF..MEM, block new fetch
//   cp0_exc_vec    out  exception vector to CP0 (COMMIT only)
//   cp0_epc_in     out  EPC value to CP0 (COMMIT only)
//   cp0_bd         out  BD flag to CP0 (COMMIT only)
//   cp0_badvaddr   out  BadVAddr to CP0 (COMMIT only)
//   cp0_eret       out  ERET pulse to CP0 (COMMIT only)
//   redirect_valid out  redirect_pc is valid (REDIRECT only)
//   redirect_pc    out  new fetch PC
//   exc_count      out  taken exception + interrupt count
// -----------------------------------------------------------------------------
module exc_sequencer #(
  parameter logic [31:0] HANDLER_ADDR = 32'hBFC00380,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid,
  input  logic [6:0]           mem_exc_vec,
  input  logic [31:0]          mem_pc,
  input  logic                 mem_bd,
  input  logic [31:0]          mem_badvaddr,
  input  logic                 mem_eret,
  input  logic                 int_pending,
  input  logic                 mem_busy,
  input  logic [31:0]          epc_value,
  input  logic                 redirect_ready,
  output logic                 flush,
  output logic [6:0]           cp0_exc_vec,
  output logic [31:0]          cp0_epc_in,
  output logic                 cp0_bd,
  output logic [31:0]          cp0_badvaddr,
  output logic                 cp0_eret,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic [CNT_WIDTH-1:0] exc_count
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    KIND_EXC  = 2'd0,
    KIND_INT  = 2'd1,
    KIND_ERET = 2'd2
  } kind_t;

  // FSM state and fields latched at accept
  state_t      state_reg;
  kind_t       kind_reg;
  logic [6:0]  vec_reg;
  logic [31:0] epc_reg;
  logic        bd_reg;
  logic [31:0] badvaddr_reg;

  // Registered outputs
  logic        flush_reg;
  logic [6:0]  cp0_exc_vec_reg;
  logic [31:0] cp0_epc_in_reg;
  logic        cp0_bd_reg;
  logic [31:0] cp0_badvaddr_reg;
  logic        cp0_eret_reg;
  logic        redirect_valid_reg;
  logic [31:0] redirect_pc_reg;

  // Event classification at the MEM stage, evaluated only in IDLE.
  logic        exc_hit;
  logic        int_hit;
  logic        eret_hit;
  logic [31:0] epc_calc;

  // Exception outranks a pending interrupt, which outranks ERET.
  assign exc_hit  = mem_valid && (|mem_exc_vec);
  assign int_hit  = mem_valid && !(|mem_exc_vec) && int_pending;
  assign eret_hit = mem_valid && !(|mem_exc_vec) && !int_pending && mem_eret;

  // A delay-slot instruction restarts at its branch; 32-bit wrap is intended.
  assign epc_calc = mem_bd ? (mem_pc - 32'd4) : mem_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= ST_IDLE;
      kind_reg           <= KIND_EXC;
      vec_reg            <= '0;
      epc_reg            <= '0;
      bd_reg             <= 1'b0;
      badvaddr_reg       <= '0;
      flush_reg          <= 1'b0;
      cp0_exc_vec_reg    <= '0;
      cp0_epc_in_reg     <= '0;
      cp0_bd_reg         <= 1'b0;
      cp0_badvaddr_reg   <= '0;
      cp0_eret_reg       <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          flush_reg          <= 1'b0;
          cp0_exc_vec_reg    <= '0;
          cp0_epc_in_reg     <= '0;
          cp0_bd_reg         <= 1'b0;
          cp0_badvaddr_reg   <= '0;
          cp0_eret_reg       <= 1'b0;
          redirect_valid_reg <= 1'b0;
          redirect_pc_reg    <= '0;
          if (exc_hit) begin
            kind_reg     <= KIND_EXC;
            vec_reg      <= mem_exc_vec;
            epc_reg      <= epc_calc;
            bd_reg       <= mem_bd;
            badvaddr_reg <= mem_badvaddr;
            flush_reg    <= 1'b1;
            state_reg    <= ST_DRAIN;
          end else if (int_hit) begin
            // CP0 raises the interrupt cause itself; only EPC/BD are needed.
            kind_reg     <= KIND_INT;
            vec_reg      <= '0;
            epc_reg      <= epc_calc;
            bd_reg       <= mem_bd;
            badvaddr_reg <= '0;
            flush_reg    <= 1'b1;
            state_reg    <= ST_DRAIN;
          end else if (eret_hit) begin
            kind_reg     <= KIND_ERET;
            vec_reg      <= '0;
            epc_reg      <= '0;
            bd_reg       <= 1'b0;
            badvaddr_reg <= '0;
            flush_reg    <= 1'b1;
            state_reg    <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          flush_reg <= 1'b1;
          // mem_busy is sampled every DRAIN cycle, so the minimum dwell is one
          // cycle and the move to COMMIT follows the first idle sample.
          if (!mem_busy) begin
            state_reg <= ST_COMMIT;
            case (kind_reg)
              KIND_EXC: begin
                cp0_exc_vec_reg  <= vec_reg;
                cp0_epc_in_reg   <= epc_reg;
                cp0_bd_reg       <= bd_reg;
                cp0_badvaddr_reg <= badvaddr_reg;
              end
              KIND_INT: begin
                cp0_epc_in_reg   <= epc_reg;
                cp0_bd_reg       <= bd_reg;
              end
              KIND_ERET: begin
                cp0_eret_reg     <= 1'b1;
              end
              default: begin
                cp0_exc_vec_reg  <= '0;
              end
            endcase
          end
        end

        ST_COMMIT: begin
          // Commit lasts exactly one cycle; CP0 outputs return to zero.
          flush_reg          <= 1'b1;
          cp0_exc_vec_reg    <= '0;
          cp0_epc_in_reg     <= '0;
          cp0_bd_reg         <= 1'b0;
          cp0_badvaddr_reg   <= '0;
          cp0_eret_reg       <= 1'b0;
          redirect_valid_reg <= 1'b1;
          // ERET returns to the EPC that CP0 presents during COMMIT.
          redirect_pc_reg    <= (kind_reg == KIND_ERET) ? epc_value : HANDLER_ADDR;
          state_reg          <= ST_REDIRECT;
        end

        ST_REDIRECT: begin
          flush_reg <= 1'b1;
          if (redirect_ready) begin
            flush_reg          <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
            vec_reg            <= '0;
            epc_reg            <= '0;
            bd_reg             <= 1'b0;
            badvaddr_reg       <= '0;
            kind_reg           <= KIND_EXC;
            state_reg          <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign flush          = flush_reg;
  assign cp0_exc_vec    = cp0_exc_vec_reg;
  assign cp0_epc_in     = cp0_epc_in_reg;
  assign cp0_bd         = cp0_bd_reg;
  assign cp0_badvaddr   = cp0_badvaddr_reg;
  assign cp0_eret       = cp0_eret_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;

`ifdef EXC_CNT_EN
  // Counts the same edge that enters COMMIT, so a reset during DRAIN never
  // counts an event that was dropped before its commit.
  logic [CNT_WIDTH-1:0] exc_count_reg;
  logic                 count_event;

  assign count_event = (state_reg == ST_DRAIN) && !mem_busy && (kind_reg != KIND_ERET);

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_count_reg <= '0;
    end else if (count_event) begin
      exc_count_reg <= exc_count_reg + CNT_WIDTH'(1);
    end
  end

  assign exc_count = exc_count_reg;
`else
  genvar gi;
  generate
    for (gi = 0; gi < CNT_WIDTH; gi++) begin : g_cnt_tie
      assign exc_count[gi] = 1'b0;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_exc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exc_sequencer
//
// Self-checking bench for exc_sequencer. Each event is described at the
// transaction level (kind, expected CP0 fields, drain/commit/redirect phase
// lengths) and every cycle of the resulting phase schedule is compared
// against the DUT outputs. Directed cases come first, then random events.
// While a sequence is in flight the MEM-stage inputs carry random traffic,
// which the sequencer must ignore.
// -----------------------------------------------------------------------------
module tb_exc_sequencer;

  localparam logic [31:0] HANDLER = 32'hBFC00380;
  localparam int          CW      = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid;
  logic [6:0]    mem_exc_vec;
  logic [31:0]   mem_pc;
  logic          mem_bd;
  logic [31:0]   mem_badvaddr;
  logic          mem_eret;
  logic          int_pending;
  logic          mem_busy;
  logic [31:0]   epc_value;
  logic          redirect_ready;
  logic          flush;
  logic [6:0]    cp0_exc_vec;
  logic [31:0]   cp0_epc_in;
  logic          cp0_bd;
  logic [31:0]   cp0_badvaddr;
  logic          cp0_eret;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] exc_count;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;

  exc_sequencer #(.HANDLER_ADDR(HANDLER), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_exc_vec(mem_exc_vec), .mem_pc(mem_pc),
    .mem_bd(mem_bd), .mem_badvaddr(mem_badvaddr), .mem_eret(mem_eret),
    .int_pending(int_pending), .mem_busy(mem_busy), .epc_value(epc_value),
    .redirect_ready(redirect_ready),
    .flush(flush), .cp0_exc_vec(cp0_exc_vec), .cp0_epc_in(cp0_epc_in),
    .cp0_bd(cp0_bd), .cp0_badvaddr(cp0_badvaddr), .cp0_eret(cp0_eret),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random MEM-stage traffic that must be ignored outside IDLE.
  task automatic junk();
    mem_valid    = 1'($urandom);
    mem_exc_vec  = 7'($urandom);
    mem_pc       = $urandom;
    mem_bd       = 1'($urandom);
    mem_badvaddr = $urandom;
    mem_eret     = 1'($urandom);
    int_pending  = 1'($urandom);
    epc_value    = $urandom;
    redirect_ready = 1'($urandom);
  endtask

  task automatic quiet();
    mem_valid = 1'b0; mem_exc_vec = '0; mem_eret = 1'b0; int_pending = 1'b0;
    mem_busy = 1'b0; redirect_ready = 1'b0;
  endtask

  task automatic chk_cp0_zero(input string tag);
    chk({tag, ".cp0_vec"},  cp0_exc_vec,  0);
    chk({tag, ".cp0_eret"}, cp0_eret,     0);
    chk({tag, ".cp0_epc"},  cp0_epc_in,   0);
  endtask

  task automatic chk_count(input string tag);
`ifdef EXC_CNT_EN
    chk({tag, ".count"}, exc_count, 64'(exp_count % (1 << CW)));
`else
    chk({tag, ".count"}, exc_count, 0);
`endif
  endtask

  // One event: present it for a cycle in IDLE, then walk the phase schedule.
  task automatic run_event(input string name, input logic valid,
                           input logic [6:0] vec, input logic [31:0] pc,
                           input logic bd, input logic [31:0] badv,
                           input logic eret, input logic intp,
                           input int busy_n, input int ready_n,
                           input logic [31:0] epcv, input bit rst_drain);
    int kind;            // 0 none, 1 exception, 2 interrupt, 3 eret
    logic [31:0] exp_epc;
    logic [31:0] exp_rpc;
    exp_epc = bd ? pc - 32'd4 : pc;
    if (!valid)          kind = 0;
    else if (vec != 0)   kind = 1;
    else if (intp)       kind = 2;
    else if (eret)       kind = 3;
    else                 kind = 0;
    exp_rpc = (kind == 3) ? epcv : HANDLER;

    mem_valid = valid; mem_exc_vec = vec; mem_pc = pc; mem_bd = bd;
    mem_badvaddr = badv; mem_eret = eret; int_pending = intp;
    mem_busy = 1'($urandom); epc_value = $urandom; redirect_ready = 1'($urandom);
    step();

    if (kind == 0) begin
      chk({name, ".noacc_flush"}, flush, 0);
      chk({name, ".noacc_rv"}, redirect_valid, 0);
      quiet();
      step();
      chk({name, ".noacc_flush2"}, flush, 0);
      return;
    end

    // DRAIN: busy for busy_n cycles, then one idle sample.
    for (int k = 1; k <= busy_n + 1; k++) begin
      chk({name, ".drain_flush"}, flush, 1);
      chk({name, ".drain_rv"}, redirect_valid, 0);
      chk_cp0_zero({name, ".drain"});
      if (rst_drain && k == 1) begin
        quiet();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_count = 0;
        chk({name, ".rst_flush"}, flush, 0);
        chk({name, ".rst_rv"}, redirect_valid, 0);
        chk({name, ".rst_rpc"}, redirect_pc, 0);
        chk_cp0_zero({name, ".rst"});
        step();
        chk({name, ".rst_idle_flush"}, flush, 0);
        chk_cp0_zero({name, ".rst_idle"});
        chk_count({name, ".rst"});
        return;
      end
      junk();
      mem_busy = (k <= busy_n);
      step();
    end

    // COMMIT
    chk({name, ".commit_flush"}, flush, 1);
    chk({name, ".commit_vec"},   cp0_exc_vec, (kind == 1) ? vec : 7'd0);
    chk({name, ".commit_epc"},   cp0_epc_in,  (kind == 3) ? 32'd0 : exp_epc);
    chk({name, ".commit_bd"},    cp0_bd,      (kind == 3) ? 1'b0 : bd);
    chk({name, ".commit_badv"},  cp0_badvaddr, (kind == 1) ? badv : 32'd0);
    chk({name, ".commit_eret"},  cp0_eret,    (kind == 3));
    chk({name, ".commit_rv"},    redirect_valid, 0);
    if (kind != 3) exp_count++;
    junk();
    mem_busy = 1'($urandom);
    epc_value = epcv;
    step();

    // REDIRECT: hold until ready
    for (int j = 0; j <= ready_n; j++) begin
      chk({name, ".redir_flush"}, flush, 1);
      chk({name, ".redir_rv"},    redirect_valid, 1);
      chk({name, ".redir_pc"},    redirect_pc, exp_rpc);
      chk_cp0_zero({name, ".redir"});
      junk();
      redirect_ready = (j == ready_n);
      step();
    end

    // Back in IDLE
    quiet();
    chk({name, ".idle_flush"}, flush, 0);
    chk({name, ".idle_rv"},    redirect_valid, 0);
    chk({name, ".idle_rpc"},   redirect_pc, 0);
    chk_cp0_zero({name, ".idle"});
    chk_count({name, ".idle"});
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    mem_pc = '0; mem_bd = 1'b0; mem_badvaddr = '0; epc_value = '0;
    step(); step();
    chk("reset.flush", flush, 0);
    chk("reset.rv", redirect_valid, 0);
    chk("reset.rpc", redirect_pc, 0);
    chk("reset.bd", cp0_bd, 0);
    chk("reset.badv", cp0_badvaddr, 0);
    chk_cp0_zero("reset");
    chk_count("reset");
    rst = 1'b0;
    step();

    // name valid vec pc bd badv eret intp busy ready epcv rst_drain
    run_event("sys",       1, 7'b0001000, 32'h0000_1000, 0, 32'h55, 0, 0, 0, 0, 32'h0, 0);
    run_event("ov_bd",     1, 7'b0010000, 32'h0000_2004, 1, 32'h66, 0, 0, 0, 0, 32'h0, 0);
    run_event("prio",      1, 7'b0000001, 32'h0000_4000, 0, 32'hDEAD_BEEF, 1, 1, 1, 0, 32'h7777, 0);
    run_event("eret_busy", 1, 7'b0000000, 32'h0000_5000, 0, 32'h0, 1, 0, 4, 0, 32'h0000_3000, 0);
    run_event("ready_hold",1, 7'b1000000, 32'h0000_6000, 0, 32'h6000, 0, 0, 0, 3, 32'h0, 0);
    run_event("rst_drain", 1, 7'b0000100, 32'h0000_7000, 0, 32'h1234, 0, 0, 2, 0, 32'h0, 1);
    run_event("bd_wrap",   1, 7'b0000010, 32'h0000_0000, 1, 32'hFFFF, 0, 0, 1, 1, 32'h0, 0);
    run_event("intr",      1, 7'b0000000, 32'h0000_8008, 1, 32'hAAAA, 1, 1, 0, 2, 32'h9999, 0);
    run_event("novalid",   0, 7'b0001000, 32'h0000_9000, 0, 32'h0, 1, 1, 0, 0, 32'h0, 0);
    run_event("noevent",   1, 7'b0000000, 32'h0000_A000, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [6:0] rvec;
      rvec = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
      run_event("rand", 1'($urandom_range(0, 7) != 0), rvec, $urandom, 1'($urandom),
                $urandom, 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                ($urandom_range(0, 14) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
